// File: rtl/z80_io_arbiter.sv
// Z80-style I/O bus cycle sequencer with round-robin arbitration between
// the CPU I/O path (requester 0) and the debug/DMA port (requester 1).
// Bus pins are decoded only from registered state and latched request.
module z80_io_arbiter #(
  parameter int NUM_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] addr_out,
  output logic        addr_oe,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  input  logic        WAIT_L
);

  localparam logic [3:0] NW    = 4'(NUM_WAIT);
  localparam logic [9:0] TO_M1 = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        owner;
  logic        winner;
  logic        we_lat;
  logic [15:0] addr_lat;
  logic [7:0]  wdata_lat;
  logic [3:0]  wcnt;     // TW cycles completed, saturates at NUM_WAIT
  logic [9:0]  tcnt;     // TW cycles spent past the mandatory count with WAIT_L low
  logic        aborted;
  logic        mand_done;
  logic        extra;
  logic        tw_done;
  logic        tw_abort;
  logic        active;
  logic        strobe;

  // The current TW cycle completes the mandatory count once wcnt >= NUM_WAIT-1;
  // a cycle is an "extra" (timeout-counted) one only when wcnt already reached it.
  assign mand_done = (wcnt >= (NW - 4'd1));
  assign extra     = (wcnt >= NW);
  assign tw_done   = mand_done && WAIT_L;
  assign tw_abort  = extra && !WAIT_L && (tcnt == TO_M1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and round-robin winner selection
  always_comb begin
    state_nxt = state;
    winner    = (req == 2'b11) ? ~last : req[1];
    case (state)
      S_IDLE:  if (|req) state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_TW;
      S_TW:    if (tw_done || tw_abort) state_nxt = S_T3;
      S_T3:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, wait/timeout counters and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      we_lat    <= 1'b0;
      addr_lat  <= 16'h0000;
      wdata_lat <= 8'h00;
      wcnt      <= 4'd0;
      tcnt      <= 10'd0;
      aborted   <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner     <= winner;
            last      <= winner;
            we_lat    <= we[winner];
            addr_lat  <= winner ? addr1 : addr0;
            wdata_lat <= winner ? wdata1 : wdata0;
            wcnt      <= 4'd0;
            tcnt      <= 10'd0;
            aborted   <= 1'b0;
          end
        end
        S_TW: begin
          if (wcnt < NW) wcnt <= wcnt + 4'd1;
          if (extra && !WAIT_L) tcnt <= tcnt + 10'd1;
          if (tw_done || tw_abort) begin
            aborted <= tw_abort;
            if (!we_lat) rdata <= tw_abort ? 8'hFF : data_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign active   = (state != S_IDLE);
  assign strobe   = (state == S_T2) || (state == S_TW);
  assign gnt      = active ? {owner, ~owner} : 2'b00;
  assign done     = (state == S_T3) ? {owner, ~owner} : 2'b00;
  assign err      = (state == S_T3) && aborted;
  assign addr_oe  = active;
  assign data_oe  = active && we_lat;
  assign addr_out = addr_lat;
  assign data_out = wdata_lat;
  assign IORQ_L   = ~strobe;
  assign RD_L     = ~(strobe && !we_lat);
  assign WR_L     = ~(strobe && we_lat);

endmodule
